// File: rtl/x2_resp_capture_if.sv
// Handshake bundle between the x2 response source, the capture stage and the result consumer.
// Latency: none, signal grouping only.
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface x2_resp_capture_if #(
  parameter int DEPTH = 4,
  parameter int W     = 7
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          start;
  logic [7:0]    len;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [15:0]   sig;

  // Capture stage side
  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, busy, done, sig
  );

  // Source/consumer side
  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, busy, done, sig
  );
endinterface

// File: rtl/x2_resp_capture.sv
// Captures a bounded window of x2 responses into a FIFO; optional MISR signature (X2_MISR_EN).
// Latency: accept to FIFO head visible 1 cycle when empty; done 1 cycle after FIFO drains.
// Backpressure: in_ready drops when FIFO full (no same-cycle pop bypass) and outside RUN.
module x2_resp_capture #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input logic            clk,
  input logic            rst,
  x2_resp_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [7:0]    r_remaining;
  logic [W-1:0]  r_mem [DEPTH];

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_pop;
  logic w_start_ok;

  // Full FIFO blocks input even if the consumer pops this cycle.
  assign w_in_ready  = (r_state == S_RUN) && (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_start_ok  = (r_state == S_IDLE) && bus.start && (bus.len != 8'd0);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  // Head is masked so an empty FIFO presents zero rather than stale storage.
  assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.count     = r_count;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);

  // FIFO storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two DEPTH makes pointer wrap free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Window sequencing: remaining count is loaded only on a legal start in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state     <= S_RUN;
            r_remaining <= bus.len;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Uses registered occupancy, so a pop emptying the FIFO is seen next cycle.
          if (r_count == '0) r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef X2_MISR_EN
  logic [15:0] r_sig;

  assign bus.sig = r_sig;

  // CRC-16-CCITT style MISR over accepted responses; held after the window ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= 16'h0000;
    end else if (w_start_ok) begin
      r_sig <= 16'h0000;
    end else if (w_accept) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(bus.in_data);
    end
  end
`else
  assign bus.sig = 16'h0000;
`endif

endmodule
